// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: PC-unit handshake, instruction-memory port and decode-side head entry.
interface fetch_queue_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] pc_in;
  logic             pc_en;
  logic             flush;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_instr;
  logic             fetch_err;

  modport master (
    input  pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output pc_en, imem_req, imem_addr, id_valid, id_pc, id_instr, fetch_err
  );

  modport slave (
    output pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  pc_en, imem_req, imem_addr, id_valid, id_pc, id_instr, fetch_err
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem request, DEPTH-entry {pc, instr} FIFO toward decode.
// Optional misaligned-PC check enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [1:0]       state;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] tag;
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic blocked;
  logic req;
  logic push;
  logic pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  logic err_q;

  assign misaligned = (bus.pc_in[1:0] != 2'b00);
  assign blocked    = err_q | misaligned;

  // Sticky until a redirect supplies a new PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (bus.flush)
      err_q <= 1'b0;
    else if (state == IDLE && misaligned)
      err_q <= 1'b1;
  end

  assign bus.fetch_err = err_q;
`else
  assign blocked       = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  // Gating with rst keeps the request quiet while the FSM is held in IDLE by reset.
  always_comb begin
    req = !rst && (state == IDLE) && (count < FULL) && !bus.flush && !blocked;
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = bus.pc_in;
  assign bus.pc_en     = req && bus.imem_gnt;

  assign push = (state == WAIT) && bus.imem_rvalid && !bus.flush;
  assign pop  = bus.id_valid && bus.id_ready;

  assign bus.id_valid = (count != '0);
  assign bus.id_pc    = pc_mem[rd_ptr];
  assign bus.id_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && bus.imem_gnt) begin
            state <= WAIT;
            tag   <= bus.pc_in;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid)
            state <= IDLE;
          else if (bus.flush)
            state <= DISCARD;
        end
        DISCARD: begin
          if (bus.imem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is reset so the head reads zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= tag;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 32, address/instruction width in bits.
REQ-002 Parameter DEPTH, default 2, queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pc_in  input  WIDTH  current PC from the PC unit.
REQ-006 pc_en  output  1  PC-advance strobe to the PC unit; high exactly in the cycle a fetch request is accepted.
REQ-007 flush  input  1  redirect, taken branch/jump; discards queued and in-flight fetches.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  WIDTH  request address, equal to pc_in.
REQ-010 imem_gnt  input  1  request accepted in the current cycle.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  WIDTH  instruction word.
REQ-013 id_valid  output  1  head entry valid toward decode.
REQ-014 id_ready  input  1  decode accepts the head entry.
REQ-015 id_pc  output  WIDTH  PC of the head entry.
REQ-016 id_instr  output  WIDTH  instruction of the head entry.
REQ-017 fetch_err  output  1  misaligned-PC flag, see Configuration.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT and DISCARD, with at most one outstanding request.
REQ-019 imem_req SHALL be high only when all hold: state is IDLE, count < DEPTH, flush is low and the PC is not blocked by fetch_err.
REQ-020 On imem_req and imem_gnt, the FSM SHALL go IDLE->WAIT, latch pc_in as the tag and pulse pc_en.
REQ-021 In WAIT with imem_rvalid and flush low, the block SHALL push {tag, imem_rdata} at the tail and return to IDLE.
REQ-022 imem_rvalid outside WAIT and DISCARD SHALL be ignored.
REQ-023 id_valid SHALL equal (count != 0), and id_pc/id_instr SHALL come directly from the head entry registers.
REQ-024 A pop SHALL occur when id_valid and id_ready are both high.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-027 flush SHALL, on the next edge, set count and both pointers to 0, regardless of any pop or push that cycle.
REQ-028 flush in WAIT without imem_rvalid SHALL move the FSM to DISCARD.
REQ-029 flush in WAIT with imem_rvalid SHALL drop the data and move the FSM to IDLE.
REQ-030 DISCARD SHALL issue no request; imem_rvalid in DISCARD SHALL drop the data and move the FSM to IDLE; flush in DISCARD SHALL keep it in DISCARD.
REQ-031 Latency: with gnt at cycle t and rvalid at t+1, id_valid SHALL be high from t+2; peak throughput is one instruction per 2 cycles.
REQ-032 Because each request reserves a free slot, a push SHALL never overflow the queue.

Reset
REQ-033 rst SHALL asynchronously force: state IDLE, count 0, pointers 0, tag 0, fetch_err 0, and therefore imem_req 0, pc_en 0, id_valid 0.
REQ-034 id_pc and id_instr SHALL read 0 while in reset.
REQ-035 A response arriving after reset is released SHALL be ignored, because the FSM is in IDLE.

Configuration
REQ-036 With FETCH_MISALIGN_CHECK_EN defined:
- pc_in[1:0] != 0 in IDLE SHALL suppress imem_req.
- fetch_err SHALL set on the next edge and stay sticky until flush.
- While fetch_err is high, no request SHALL issue.
REQ-037 Without FETCH_MISALIGN_CHECK_EN, fetch_err SHALL be tied 0 and no alignment check SHALL exist.

Verification
REQ-038 Basic fetch: pc_in=0x00000000, gnt=1, rvalid next cycle with rdata 0x00500093 -> two cycles after gnt: id_valid=1, id_pc=0x0, id_instr=0x00500093.
REQ-039 Full queue: id_ready=0, fetches at 0x0 and 0x4 complete -> count=2, imem_req=0, pc_en=0; one pop -> imem_req=1 the next cycle.
REQ-040 Flush in WAIT: gnt at 0x8, flush next cycle, rvalid 0xDEADBEEF one cycle later -> FSM passes through DISCARD, data dropped, id_valid stays 0.
REQ-041 Flush with rvalid in the same cycle: data dropped, FSM IDLE, queue empty, imem_req=1 the following cycle.
REQ-042 Reset in WAIT: rst pulse mid-request -> all outputs 0 immediately; a later rvalid is not queued.
REQ-043 Misalignment, macro defined: pc_in=0x00000002 -> imem_req=0, fetch_err=1 until flush. Macro undefined: imem_req=1 and fetch_err=0.
